data_memory_banked: RTL and testbench
=====================================

# data_memory_banked

Parametrised, self-initialising synchronous data memory that replaces the fixed 32×8 data memory in the datapath. It adds configurable width, depth and read latency, a hardware zeroing sweep after reset or on request, a ready/valid handshake toward the control unit, and out-of-range address detection. Reads and writes issued in the same cycle are both serviced.

## Interface
Parameters:
- DATA_WIDTH, 8, word width in bits
- DEPTH, 32, number of words, ≥2
- ADDR_WIDTH, $clog2(DEPTH), address width; may be set wider than needed
- READ_LATENCY, 1, read latency in cycles, legal values 1 or 2

Ports:
- clock  in  1  single clock; all logic on the rising edge
- clear_n  in  1  reset, asynchronous and active-low
- init  in  1  request a zeroing sweep; sampled only while ready=1
- signal_memread  in  1  read request
- signal_memwrite  in  1  write request
- address  in  ADDR_WIDTH  word address for read and write
- data_to_write  in  DATA_WIDTH  write data
- ready  out  1  block accepts requests
- data_out  out  DATA_WIDTH  read data
- data_valid  out  1  data_out carries a new read result this cycle
- addr_error  out  1  one-cycle pulse reporting an out-of-range access

## Operation
- Two states: ST_SWEEP and ST_READY.
- Reset (clear_n=0) forces:
  - state=ST_SWEEP, sweep counter=0
  - ready=0, data_valid=0, addr_error=0, data_out=0
  - read pipeline cleared
  - Array contents are not reset directly.
- ST_SWEEP:
  - Each edge writes 0 to memory[counter], then increments counter.
  - The edge that writes DEPTH-1 moves to ST_READY and sets ready=1.
  - All requests are ignored: no write, no data_valid, no addr_error.
  - init is ignored.
- ST_READY:
  - A request is accepted on any edge with ready=1.
  - init has priority. It moves to ST_SWEEP with counter=0 and ready=0, and any read/write on that edge is dropped.
  - Reads already in the pipeline still complete.
- In range means address < DEPTH.
- Write, in range: memory[address] ← data_to_write on the accepting edge.
- Read, in range: returns memory[address] as it was before that edge (read-first).
- Read and write on the same edge, same address: the read returns the old data and the write commits.
- Out of range, any access: no array change. addr_error pulses for 1 cycle.
- Out-of-range read: still produces data_valid with data_out=0, and addr_error is coincident with data_valid.
- Out-of-range write only: addr_error asserts on the cycle after acceptance.
- Read plus write, both out of range: a single addr_error pulse, aligned with data_valid.
- data_out holds its last value when data_valid=0.

## Timing
- After clear_n rises, ready=1 after exactly DEPTH rising edges. Same after an accepted init.
- Read latency: data_valid and data_out are valid READ_LATENCY cycles after the accepting edge.
  - READ_LATENCY=2 adds one output register stage.
- Throughput: one read and one write per cycle, back-to-back, no bubbles.
- Reset asserted mid-sweep or mid-read: immediate return to reset values; the sweep restarts from 0.
- Write data is visible to a read accepted on the following edge.

## Structure
- Package data_memory_pkg holds:
  - state typedef {ST_SWEEP, ST_READY}
  - default DATA_WIDTH and DEPTH constants
  - legal READ_LATENCY values
- One sub-module, memory_array: storage only, parametrised DATA_WIDTH/DEPTH, one synchronous write port, one synchronous read-first port.
- The sweep FSM, range check and latency pipeline live in data_memory_banked.
- Elaboration check: error if READ_LATENCY ∉ {1,2} or 2**ADDR_WIDTH < DEPTH.

## Test plan
- Reset then wait, DEPTH=32:
  - ready=0 for 32 edges, then 1.
  - Read every address → all data_out=0.
- Write 0xA5 to address 3, then read address 3:
  - READ_LATENCY=1: data_valid one cycle after acceptance with 0xA5.
  - READ_LATENCY=2: data_valid two cycles after acceptance with 0xA5.
- Same-edge read+write to address 7, old value 0x11, new value 0x22:
  - That read returns 0x11.
  - The next read returns 0x22.
- DEPTH=20, ADDR_WIDTH=5:
  - Write to address 25 → addr_error pulse one cycle later, no array change.
  - Read address 25 → data_valid with 0x00 and addr_error together.
- init pulse with reads in flight:
  - In-flight reads complete with the old data.
  - ready=0 for DEPTH edges.
  - Requests during the sweep produce no response.
  - Afterwards, address 3 reads 0x00.
- clear_n asserted halfway through the sweep and during an outstanding read:
  - Outputs drop to 0 immediately.
  - No data_valid appears.
  - The full DEPTH-edge sweep reruns.

Source files
------------

// File: rtl/data_memory_banked_pkg.sv
// Shared types and defaults for the self-initialising banked data memory.
package data_memory_pkg;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_DEPTH        = 32;
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    function automatic bit latency_legal(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/data_memory_banked_if.sv
// Request/response bundle between the control unit (master) and the data memory (slave).
interface data_memory_banked_if #(
    parameter int DATA_WIDTH = data_memory_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(data_memory_pkg::DEF_DEPTH)
);
    logic                  init;
    logic                  signal_memread;
    logic                  signal_memwrite;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_to_write;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  addr_error;

    modport master (
        output init, signal_memread, signal_memwrite, address, data_to_write,
        input  ready, data_out, data_valid, addr_error
    );

    modport slave (
        input  init, signal_memread, signal_memwrite, address, data_to_write,
        output ready, data_out, data_valid, addr_error
    );
endinterface

// File: rtl/data_memory_banked_memory_array.sv
// Plain storage: one synchronous write port and one synchronous read-first port, no reset.
module memory_array #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Same-edge read of a written word returns the pre-edge contents.
    always_ff @(posedge clock) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_memory_banked.sv
// Data memory with zeroing sweep, ready handshake, range check and 1/2-cycle read pipeline.
module data_memory_banked
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 1
) (
    input logic                 clock,
    input logic                 clear_n,
    data_memory_banked_if.slave bus
);
    localparam int MAW = $clog2(DEPTH);

    if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("data_memory_banked: READ_LATENCY must be 1 or 2");
    end
    if ((longint'(1) << ADDR_WIDTH) < longint'(DEPTH)) begin : g_bad_addr_width
        $error("data_memory_banked: ADDR_WIDTH too narrow for DEPTH");
    end

    state_t                state_q, state_d;
    logic [MAW-1:0]        cnt_q, cnt_d;
    logic                  ready, accept, in_range, rd_acc, wr_acc;
    logic                  mem_we, mem_re;
    logic [MAW-1:0]        mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata, rd_word;
    logic                  v1_q, v1_d, z1_q, z1_d, e1_q, e1_d, ew1_q, ew1_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;

    assign in_range = (64'(bus.address) < 64'(DEPTH));

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SWEEP: begin
                if (cnt_q == MAW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (bus.init) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_SWEEP;
        endcase
    end

    // init wins over any read/write presented on the same edge.
    always_comb begin
        ready     = (state_q == ST_READY);
        accept    = ready && !bus.init;
        rd_acc    = accept && bus.signal_memread;
        wr_acc    = accept && bus.signal_memwrite;
        mem_re    = rd_acc && in_range;
        mem_we    = wr_acc && in_range;
        mem_waddr = bus.address[MAW-1:0];
        mem_wdata = bus.data_to_write;
        if (state_q == ST_SWEEP) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end
    end

    memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (MAW)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (bus.address[MAW-1:0]),
        .rdata (mem_rdata)
    );

    // A read-accompanied error rides with the read; a lone bad write reports next cycle.
    always_comb begin
        v1_d    = rd_acc;
        z1_d    = !in_range;
        e1_d    = rd_acc && !in_range;
        ew1_d   = wr_acc && !rd_acc && !in_range;
        rd_word = z1_q ? '0 : mem_rdata;
        out_d   = v1_q ? rd_word : out_q;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            v1_q  <= 1'b0;
            z1_q  <= 1'b0;
            e1_q  <= 1'b0;
            ew1_q <= 1'b0;
            out_q <= '0;
        end else begin
            v1_q  <= v1_d;
            z1_q  <= z1_d;
            e1_q  <= e1_d;
            ew1_q <= ew1_d;
            out_q <= out_d;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic v2_q, e2_q;
        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
                v2_q <= 1'b0;
                e2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
                e2_q <= e1_q;
            end
        end
        assign bus.data_valid = v2_q;
        assign bus.data_out   = out_q;
        assign bus.addr_error = e2_q || ew1_q;
    end else begin : g_lat1
        assign bus.data_valid = v1_q;
        assign bus.data_out   = out_d;
        assign bus.addr_error = e1_q || ew1_q;
    end

    assign bus.ready = ready;
endmodule

// File: tb/tb_data_memory_banked.sv
// Drives a DEPTH=32/latency-1 and a DEPTH=20/latency-2 instance in lockstep against hand-built expectations.
module tb_data_memory_banked;
    logic       clock   = 1'b0;
    logic       clear_n = 1'b0;
    logic       init_i  = 1'b0;
    logic       rd_i    = 1'b0;
    logic       wr_i    = 1'b0;
    logic [4:0] addr_i  = '0;
    logic [7:0] wd_i    = '0;

    always #5 clock = ~clock;

    data_memory_banked_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) if_a ();
    data_memory_banked_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) if_b ();

    assign if_a.init = init_i;  assign if_a.signal_memread = rd_i;  assign if_a.signal_memwrite = wr_i;
    assign if_a.address = addr_i;  assign if_a.data_to_write = wd_i;
    assign if_b.init = init_i;  assign if_b.signal_memread = rd_i;  assign if_b.signal_memwrite = wr_i;
    assign if_b.address = addr_i;  assign if_b.data_to_write = wd_i;

    data_memory_banked #(.DATA_WIDTH(8), .DEPTH(32), .ADDR_WIDTH(5), .READ_LATENCY(1)) dut_a (
        .clock(clock), .clear_n(clear_n), .bus(if_a));
    data_memory_banked #(.DATA_WIDTH(8), .DEPTH(20), .ADDR_WIDTH(5), .READ_LATENCY(2)) dut_b (
        .clock(clock), .clear_n(clear_n), .bus(if_b));

    typedef struct packed {
        bit       rd;
        bit       wr;
        bit [4:0] addr;
        bit [7:0] wd;
        bit [7:0] ea;
        bit       erra;
        bit [7:0] eb;
        bit       errb;
    } vec_t;

    int       checks = 0;
    int       errors = 0;
    int       cyc    = 0;
    bit       ev_a [4096];
    bit       ee_a [4096];
    bit [7:0] ed_a [4096];
    bit       ev_b [4096];
    bit       ee_b [4096];
    bit [7:0] ed_b [4096];
    logic [7:0] hold_a = '0;
    logic [7:0] hold_b = '0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_ready_a"}, if_a.ready, 1'b0);
        chk1({tag, "_valid_a"}, if_a.data_valid, 1'b0);
        chk1({tag, "_err_a"}, if_a.addr_error, 1'b0);
        chk8({tag, "_data_a"}, if_a.data_out, 8'h00);
        chk1({tag, "_ready_b"}, if_b.ready, 1'b0);
        chk1({tag, "_valid_b"}, if_b.data_valid, 1'b0);
        chk1({tag, "_err_b"}, if_b.addr_error, 1'b0);
        chk8({tag, "_data_b"}, if_b.data_out, 8'h00);
    endtask

    // Per-edge check of valid/error/data against the expectation schedule.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (cyc < 4096) begin
                chk1("valid_a", if_a.data_valid, ev_a[cyc]);
                chk1("err_a", if_a.addr_error, ee_a[cyc]);
                if (ev_a[cyc]) hold_a = ed_a[cyc];
                chk8("data_a", if_a.data_out, hold_a);
                chk1("valid_b", if_b.data_valid, ev_b[cyc]);
                chk1("err_b", if_b.addr_error, ee_b[cyc]);
                if (ev_b[cyc]) hold_b = ed_b[cyc];
                chk8("data_b", if_b.data_out, hold_b);
            end
        end
    end

    task automatic drive(input bit rd, input bit wr, input bit [4:0] addr, input bit [7:0] wd,
                         input bit sch_a, input bit [7:0] ea, input bit erra,
                         input bit sch_b, input bit [7:0] eb, input bit errb);
        int e;
        @(negedge clock);
        rd_i = rd;  wr_i = wr;  addr_i = addr;  wd_i = wd;
        e = cyc + 1;
        if (sch_a) begin
            if (rd) begin
                ev_a[e] = 1'b1;  ed_a[e] = ea;  ee_a[e] = ee_a[e] | erra;
            end else if (wr && erra) ee_a[e] = 1'b1;
        end
        if (sch_b) begin
            if (rd) begin
                ev_b[e+1] = 1'b1;  ed_b[e+1] = eb;  ee_b[e+1] = ee_b[e+1] | errb;
            end else if (wr && errb) ee_b[e] = 1'b1;
        end
    endtask

    task automatic idle();
        @(negedge clock);
        rd_i = 1'b0;  wr_i = 1'b0;  init_i = 1'b0;
    endtask

    // Counts edges until each instance raises ready; the first `noise` edges carry ignored requests.
    task automatic wait_ready(input int noise, output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 1; i <= 64 && (na == 0 || nb == 0); i++) begin
            rd_i = (i <= noise);  wr_i = (i <= noise);  addr_i = 5'd3;  wd_i = 8'hEE;
            @(posedge clock);
            #2;
            if (na == 0 && if_a.ready) na = i;
            if (nb == 0 && if_b.ready) nb = i;
        end
        rd_i = 1'b0;
        wr_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [15];
        int   na, nb;
        //           rd    wr    addr   wd     ea     erra  eb     errb
        vecs = '{ '{1'b0, 1'b1, 5'd3,  8'hA5, 8'h00, 1'b0, 8'h00, 1'b0},
                  '{1'b1, 1'b0, 5'd3,  8'h00, 8'hA5, 1'b0, 8'hA5, 1'b0},
                  '{1'b0, 1'b1, 5'd7,  8'h11, 8'h00, 1'b0, 8'h00, 1'b0},
                  '{1'b1, 1'b1, 5'd7,  8'h22, 8'h11, 1'b0, 8'h11, 1'b0},
                  '{1'b1, 1'b0, 5'd7,  8'h00, 8'h22, 1'b0, 8'h22, 1'b0},
                  '{1'b0, 1'b1, 5'd25, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b1},
                  '{1'b1, 1'b0, 5'd25, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b1},
                  '{1'b1, 1'b1, 5'd25, 8'h77, 8'h5A, 1'b0, 8'h00, 1'b1},
                  '{1'b1, 1'b0, 5'd25, 8'h00, 8'h77, 1'b0, 8'h00, 1'b1},
                  '{1'b1, 1'b0, 5'd19, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0},
                  '{1'b0, 1'b1, 5'd20, 8'hC3, 8'h00, 1'b0, 8'h00, 1'b1},
                  '{1'b1, 1'b0, 5'd20, 8'h00, 8'hC3, 1'b0, 8'h00, 1'b1},
                  '{1'b1, 1'b0, 5'd31, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1},
                  '{1'b0, 1'b1, 5'd0,  8'hFF, 8'h00, 1'b0, 8'h00, 1'b0},
                  '{1'b1, 1'b0, 5'd0,  8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0} };

        #12;
        chk_quiet("reset");
        @(negedge clock);
        clear_n = 1'b1;
        wait_ready(0, na, nb);
        chkn("sweep_edges_a", na, 32);
        chkn("sweep_edges_b", nb, 20);

        for (int a = 0; a < 32; a++)
            drive(1'b1, 1'b0, 5'(a), 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, (a >= 20));
        idle();

        for (int i = 0; i < 15; i++)
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                  1'b1, vecs[i].ea, vecs[i].erra, 1'b1, vecs[i].eb, vecs[i].errb);
        idle();
        repeat (3) @(negedge clock);

        // init right behind two reads: both reads must still come back with pre-sweep data.
        drive(1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0);
        drive(1'b1, 1'b0, 5'd7, 8'h00, 1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0);
        @(negedge clock);
        init_i = 1'b1;  rd_i = 1'b1;  wr_i = 1'b1;  addr_i = 5'd3;  wd_i = 8'h99;
        @(negedge clock);
        init_i = 1'b0;
        wait_ready(19, na, nb);
        chkn("init_sweep_edges_a", na, 32);
        chkn("init_sweep_edges_b", nb, 20);
        drive(1'b1, 1'b0, 5'd3,  8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 5'd25, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
        drive(1'b1, 1'b0, 5'd7,  8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        idle();
        repeat (3) @(negedge clock);

        // Reset lands while dut_b's read is still in its pipeline.
        drive(1'b0, 1'b1, 5'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        rd_i = 1'b0;  wr_i = 1'b0;
        clear_n = 1'b0;
        hold_a = '0;
        hold_b = '0;
        #1;
        chk_quiet("reset_mid_read");
        @(negedge clock);
        clear_n = 1'b1;
        repeat (16) @(posedge clock);
        @(negedge clock);
        chk1("mid_sweep_ready_a", if_a.ready, 1'b0);
        chk1("mid_sweep_ready_b", if_b.ready, 1'b0);
        clear_n = 1'b0;
        #1;
        chk_quiet("reset_mid_sweep");
        @(negedge clock);
        clear_n = 1'b1;
        wait_ready(0, na, nb);
        chkn("resweep_edges_a", na, 32);
        chkn("resweep_edges_b", nb, 20);
        drive(1'b1, 1'b0, 5'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        idle();
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
